// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an ARR_SIZE x ARR_SIZE systolic MAC array: weight load, skewed activation feed, result deskew.
// Optional macro SYSTOLIC_SEQ_PERF_EN adds perf_stall_cyc (LOAD/FEED stall cycles of the current job).
module systolic_seq_ctrl #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16,
    parameter int VERTICAL_BW   = 32,
    parameter int ROWS_W        = 16,
    parameter int ARR_LAT       = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROWS_W-1:0]                 cfg_rows,
    output logic                              busy,
    output logic                              done,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] w_data,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [ARR_SIZE*HORIZONTAL_BW-1:0] a_data,
    output logic                              arr_mode,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] arr_vert,
    output logic [ARR_SIZE*HORIZONTAL_BW-1:0] arr_horz,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0]   arr_result,
    output logic                              res_valid,
    output logic                              res_last,
    output logic [ARR_SIZE*VERTICAL_BW-1:0]   res_data
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [31:0]                       perf_stall_cyc
`endif
);

    localparam int HW     = ARR_SIZE * HORIZONTAL_BW;
    localparam int VW     = ARR_SIZE * VERTICAL_BW;
    localparam int TAG_D  = ARR_LAT + ARR_SIZE;
    localparam int WCNT_W = $clog2(ARR_SIZE + 1);

    // state | meaning: IDLE wait start | LOAD weight rows | FEED activations | DRAIN flush tags | DONE pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [WCNT_W-1:0]   w_left;
    logic [ROWS_W-1:0]   rows_left;
    logic                w_xfer, a_xfer, a_final, start_acc, tag_busy;
    logic [TAG_D-1:0]    tag_v, tag_l;
    logic [HW-1:0]       feed_in;
    logic [VW-1:0]       aligned;
    logic                mode_q;
    logic [HW-1:0]       vert_q;

    assign w_xfer    = w_valid & w_ready;
    assign a_xfer    = a_valid & a_ready;
    assign a_final   = a_xfer & (rows_left == ROWS_W'(1));
    assign start_acc = (state == S_IDLE) & start;
    assign tag_busy  = |tag_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_valid && w_left == WCNT_W'(1))
                    state_nxt = (rows_left == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                a_ready = 1'b1;
                if (a_valid && rows_left == ROWS_W'(1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (!tag_busy) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_left    <= '0;
            rows_left <= '0;
        end else if (start_acc) begin
            w_left    <= WCNT_W'(ARR_SIZE);
            rows_left <= cfg_rows;
        end else begin
            if (w_xfer) w_left <= w_left - WCNT_W'(1);
            if (a_xfer) rows_left <= rows_left - ROWS_W'(1);
        end
    end

    // Stall cycles in LOAD leave the array in compute mode with zero inputs (a no-op).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            vert_q <= '0;
        end else begin
            mode_q <= w_xfer;
            vert_q <= w_xfer ? w_data : '0;
        end
    end

    assign arr_mode = mode_q;
    assign arr_vert = vert_q;
    assign feed_in  = a_xfer ? a_data : '0;

    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_skew
        logic [HORIZONTAL_BW-1:0] sk [0:i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) sk[k] <= '0;
            end else begin
                sk[0] <= feed_in[i*HORIZONTAL_BW +: HORIZONTAL_BW];
                for (int k = 1; k <= i; k++) sk[k] <= sk[k-1];
            end
        end
        assign arr_horz[i*HORIZONTAL_BW +: HORIZONTAL_BW] = sk[i];
    end

    // Column j leaves the array j cycles after column 0; delay it so all columns line up.
    for (genvar j = 0; j < ARR_SIZE; j++) begin : g_align
        localparam int D = ARR_SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*VERTICAL_BW +: VERTICAL_BW] = arr_result[j*VERTICAL_BW +: VERTICAL_BW];
        end else begin : g_dly
            logic [VERTICAL_BW-1:0] dl [0:D-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dl[k] <= '0;
                end else begin
                    dl[0] <= arr_result[j*VERTICAL_BW +: VERTICAL_BW];
                    for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
                end
            end
            assign aligned[j*VERTICAL_BW +: VERTICAL_BW] = dl[D-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v     <= '0;
            tag_l     <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
        end else begin
            tag_v     <= {tag_v[TAG_D-2:0], a_xfer};
            tag_l     <= {tag_l[TAG_D-2:0], a_final};
            res_valid <= tag_v[TAG_D-1];
            res_last  <= tag_v[TAG_D-1] & tag_l[TAG_D-1];
            res_data  <= tag_v[TAG_D-1] ? aligned : '0;
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic        stall_now;

    assign stall_now = ((state == S_LOAD) & ~w_valid) | ((state == S_FEED) & ~a_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                stall_cnt <= '0;
        else if (start_acc)                     stall_cnt <= '0;
        else if (stall_now && stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
    end

    assign perf_stall_cyc = stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl: behavioural MAC-array model drives arr_result,
// a job-level scoreboard predicts every result vector from the transferred weights and activations.
module tb_systolic_seq_ctrl;
    localparam int N = 4, HB = 16, VB = 32, RW = 16, LAT = 5;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [RW-1:0]   cfg_rows = '0;
    logic            busy, done, w_valid = 1'b0, w_ready, a_valid = 1'b0, a_ready;
    logic [N*HB-1:0] w_data = '0, a_data = '0, arr_vert, arr_horz;
    logic            arr_mode, res_valid, res_last;
    logic [N*VB-1:0] arr_result = '0, res_data;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]     perf_stall_cyc;
`endif

    systolic_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .arr_mode(arr_mode), .arr_vert(arr_vert), .arr_horz(arr_horz), .arr_result(arr_result),
        .res_valid(res_valid), .res_last(res_last), .res_data(res_data)
`ifdef SYSTOLIC_SEQ_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Weight-stationary array model: vector whose lane 0 appears in cycle c yields column j in cycle c+LAT+j.
    logic [HB-1:0] hist [16][N];
    logic [HB-1:0] wm [N][N];
    int            acyc = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            for (int t = 0; t < 16; t++) for (int i = 0; i < N; i++) hist[t][i] = '0;
            arr_result = '0;
        end else begin
            logic [VB-1:0] acc;
            acyc++;
            for (int i = 0; i < N; i++) hist[acyc & 15][i] = arr_horz[i*HB +: HB];
            if (arr_mode) begin
                for (int r = N - 1; r > 0; r--) for (int c = 0; c < N; c++) wm[r][c] = wm[r-1][c];
                for (int c = 0; c < N; c++) wm[0][c] = arr_vert[c*HB +: HB];
            end
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int i = 0; i < N; i++)
                    acc = acc + VB'(hist[(acyc - LAT - j + i) & 15][i]) * VB'(wm[i][j]);
                arr_result[j*VB +: VB] = acc;
            end
        end
    end

    typedef struct { logic [N*VB-1:0] d; logic last; } exp_t;
    exp_t            expq[$];
    exp_t            e;
    int              res_cnt = 0;
    time             first_res_t = 0, last_res_t = 0;
    logic [N*VB-1:0] last_res_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (expq.size() == 0) chk("res_unexpected", res_valid, 1'b0);
                else begin
                    e = expq.pop_front();
                    chk("res_data", res_data, e.d);
                    chk("res_last", res_last, e.last);
                end
                if (res_cnt == 0) first_res_t = $time;
                if (res_last) last_res_t = $time;
                res_cnt++;
                last_res_data = res_data;
            end else begin
                chk("idle_res_data", res_data, '0);
                chk("idle_res_last", res_last, 1'b0);
            end
        end
    end

    // stall: 0 none, 1 activation bubble every other FEED cycle, 2 random on both streams
    task automatic run_job(input int rows, input int wmode, input int amode, input int stall,
                           input bit poke, input bit abort);
        logic [N*HB-1:0] wexp [N];
        logic [N*VB-1:0] y;
        logic [VB-1:0]   acc;
        int  wt = 0, at = 0, stalls = 0, fcyc = 0, tmo = 0;
        bit  got_done = 0, exp_wr, exp_ar, wv, av;
        time first_x = 0;
        expq.delete();
        res_cnt = 0; first_res_t = 0; last_res_t = 0;
        @(negedge clk);
        start = 1'b1; cfg_rows = RW'(rows);
        @(negedge clk);
        start = 1'b0; cfg_rows = RW'($urandom);
        chk("busy_after_start", busy, 1'b1);
        while (tmo < rows * 4 + 200) begin
            start = 1'b0;
            if (done) begin got_done = 1; break; end
            chk("busy_in_job", busy, 1'b1);
            exp_wr = (wt < N);
            exp_ar = (wt == N) && (at < rows);
            chk("w_ready", w_ready, exp_wr);
            chk("a_ready", a_ready, exp_ar);
            wv = (stall == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall == 1)      av = (fcyc % 2 == 0);
            else if (stall == 2) av = ($urandom_range(0, 2) != 0);
            else                 av = 1'b1;
            for (int l = 0; l < N; l++) begin
                case (wmode)
                    1:       w_data[l*HB +: HB] = (l == N - 1 - wt) ? HB'(1) : HB'(0);
                    2:       w_data[l*HB +: HB] = HB'(N - wt);
                    default: w_data[l*HB +: HB] = HB'($urandom);
                endcase
                a_data[l*HB +: HB] = (amode == 1) ? HB'(1) : HB'($urandom);
            end
            w_valid = exp_wr ? wv : 1'($urandom_range(0, 1));
            a_valid = exp_ar ? av : 1'($urandom_range(0, 1));
            if (exp_wr && !wv) stalls++;
            if (exp_ar && !av) stalls++;
            if (exp_ar) fcyc++;
            if (poke && exp_ar && at == 1) begin start = 1'b1; cfg_rows = RW'(7); end
            if (exp_wr && wv) begin wexp[N-1-wt] = w_data; wt++; end
            if (exp_ar && av) begin
                for (int j = 0; j < N; j++) begin
                    acc = '0;
                    for (int i = 0; i < N; i++)
                        acc = acc + VB'(a_data[i*HB +: HB]) * VB'(wexp[i][j*HB +: HB]);
                    y[j*VB +: VB] = acc;
                end
                if (wmode == 1) begin
                    logic [N*VB-1:0] zx;
                    for (int j = 0; j < N; j++) zx[j*VB +: VB] = VB'(a_data[j*HB +: HB]);
                    chk("model_identity", y, zx);
                end
                if (at == 0) first_x = $time;
                at++;
                expq.push_back('{d: y, last: (at == rows)});
            end
            if (abort && at >= 2) begin
                #2 rst = 1'b1;
                expq.delete();
                #1;
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_ready", {w_ready, a_ready, arr_mode}, 3'b000);
                chk("abort_arr_vert", arr_vert, '0);
                chk("abort_arr_horz", arr_horz, '0);
                chk("abort_res", {res_valid, res_last, res_data}, '0);
                @(negedge clk);
                rst = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    chk("abort_stays_idle", busy, 1'b0);
                end
                return;
            end
            @(negedge clk);
            tmo++;
        end
        w_valid = 1'b0; a_valid = 1'b0;
        chk("job_done_seen", got_done, 1'b1);
        chk("rows_taken", at, rows);
        chk("res_count", res_cnt, rows);
        chk("expq_empty", expq.size(), 0);
        if (rows > 0) chk("done_within_2", ($time - last_res_t) <= 20, 1'b1);
        if (rows > 0 && wmode == 2 && amode == 1) begin
            chk("first_res_offset", int'((first_res_t - first_x) / 10), LAT + N + 1);
            for (int j = 0; j < N; j++) chk("lane_eq_10", last_res_data[j*VB +: VB], 32'd10);
        end
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("perf_stall_cyc", perf_stall_cyc, stalls);
`endif
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 2'b00);
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("perf_held", perf_stall_cyc, stalls);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_ready", {w_ready, a_ready, arr_mode}, 3'b000);
        chk("rst_arr_vert", arr_vert, '0);
        chk("rst_arr_horz", arr_horz, '0);
        chk("rst_res", {res_valid, res_last, res_data}, '0);
        rst = 1'b0;
        @(negedge clk);
        run_job(4, 1, 0, 0, 0, 0);
        run_job(4, 1, 0, 1, 0, 0);
        run_job(0, 0, 0, 0, 0, 0);
        run_job(6, 0, 0, 2, 1, 0);
        run_job(8, 0, 0, 0, 0, 1);
        run_job(5, 0, 0, 2, 0, 0);
        run_job(4, 2, 1, 0, 0, 0);
        for (int r = 0; r < 6; r++)
            run_job($urandom_range(1, 12), 0, 0, 2, 1'($urandom_range(0, 1)), 0);
        run_job(300, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
